// File: rtl/boa_stage_if.sv
// Boa32 instruction fetch stage: PC generation, credit-limited in-order imem reads,
// and a small {pc, insn} queue feeding decode over valid/ready.
module boa_stage_if #(
   parameter logic [31:0] ENTRY_PC = 32'h4000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_re,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        fw_branch,
   input  logic [31:0] fw_branch_addr,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_insn,
   input  logic        id_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

   logic [31:0]   r_pc;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_drop;
   logic [31:0]   r_rq_pc [DEPTH];
   logic [AW-1:0] r_rq_head, r_rq_tail;
   logic [31:0]   r_oq_pc   [DEPTH];
   logic [31:0]   r_oq_insn [DEPTH];
   logic [AW-1:0] r_oq_head, r_oq_tail;
   logic [CW-1:0] r_occ;

   logic          w_pop, w_acc, w_rsp, w_push;
   logic [CW:0]   w_credit;
   logic [1:0]    w_unused_addr_lo;

   assign w_unused_addr_lo = fw_branch_addr[1:0];

   assign id_valid  = (r_occ != '0);
   assign id_pc     = r_oq_pc[r_oq_head];
   assign id_insn   = r_oq_insn[r_oq_head];
   assign imem_addr = r_pc;

   // A slot freed by this cycle's pop can already be claimed by a new request.
   assign w_pop    = id_valid && id_ready;
   assign w_credit = {1'b0, r_out} + {1'b0, r_occ} - (CW+1)'(w_pop);
   assign imem_re  = rst && !fw_branch && (w_credit < LIM);
   assign w_acc    = imem_re && imem_ready;
   assign w_rsp    = imem_rvalid && (r_out != '0);
   assign w_push   = w_rsp && (r_drop == '0) && !fw_branch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc      <= ENTRY_PC;
         r_out     <= '0;
         r_drop    <= '0;
         r_rq_head <= '0;
         r_rq_tail <= '0;
         for (int i = 0; i < DEPTH; i++) r_rq_pc[i] <= '0;
      end else begin
         if (fw_branch)  r_pc <= {fw_branch_addr[31:2], 2'b00};
         else if (w_acc) r_pc <= r_pc + 32'd4;

         r_out <= r_out + CW'(w_acc) - CW'(w_rsp);

         if (w_acc) begin
            r_rq_pc[r_rq_tail] <= r_pc;
            r_rq_tail          <= r_rq_tail + AW'(1);
         end
         if (w_rsp) r_rq_head <= r_rq_head + AW'(1);

         // Everything still outstanding after this cycle is stale once we redirect.
         if (fw_branch)                  r_drop <= r_out - CW'(w_rsp);
         else if (w_rsp && r_drop != '0) r_drop <= r_drop - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_oq_head <= '0;
         r_oq_tail <= '0;
         r_occ     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_oq_pc[i]   <= '0;
            r_oq_insn[i] <= '0;
         end
      end else if (fw_branch) begin
         r_oq_head <= '0;
         r_oq_tail <= '0;
         r_occ     <= '0;
      end else begin
         if (w_push) begin
            r_oq_pc[r_oq_tail]   <= r_rq_pc[r_rq_head];
            r_oq_insn[r_oq_tail] <= imem_rdata;
            r_oq_tail            <= r_oq_tail + AW'(1);
         end
         if (w_pop) r_oq_head <= r_oq_head + AW'(1);
         r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: tb/tb_boa_stage_if.sv
// Directed bench for boa_stage_if with a fixed-latency in-order memory model.
module tb_boa_stage_if;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_re;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        fw_branch = 1'b0;
   logic [31:0] fw_branch_addr = '0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_insn;
   logic        id_ready = 1'b0;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int lat     = 1;
   bit spurious = 1'b0;

   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] acc_addr[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_insn[$];

   boa_stage_if dut (
      .clk            (clk),
      .rst            (rst),
      .imem_re        (imem_re),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .fw_branch      (fw_branch),
      .fw_branch_addr (fw_branch_addr),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_insn        (id_insn),
      .id_ready       (id_ready)
   );

   always #5 clk = ~clk;

   // One clock cycle: drive memory response, log accepts/pops mid-cycle, advance.
   task automatic clk_cycle();
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mq_addr[0] ^ 32'hA5A5_A5A5;
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else if (spurious) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      @(negedge clk);
      if (imem_re && imem_ready) begin
         acc_addr.push_back(imem_addr);
         mq_addr.push_back(imem_addr);
         mq_due.push_back(cyc + lat);
      end
      if (id_valid && id_ready) begin
         pop_pc.push_back(id_pc);
         pop_insn.push_back(id_insn);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_model();
      mq_addr.delete();
      mq_due.delete();
      acc_addr.delete();
      pop_pc.delete();
      pop_insn.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      spurious    = 1'b0;
      cyc         = 0;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      fw_branch = 1'b0;
      id_ready  = 1'b0;
      clear_model();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      imem_ready = 1'b1;
      #3;
      n_total++;
      if (imem_re !== 1'b0) $display("FAIL reset_imem_re got %b expected 0", imem_re);
      else n_pass++;
      n_total++;
      if (id_valid !== 1'b0) $display("FAIL reset_id_valid got %b expected 0", id_valid);
      else n_pass++;
      n_total++;
      if (id_pc !== 32'h0) $display("FAIL reset_id_pc got %h expected 00000000", id_pc);
      else n_pass++;
      n_total++;
      if (id_insn !== 32'h0) $display("FAIL reset_id_insn got %h expected 00000000", id_insn);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (imem_re !== 1'b1) $display("FAIL release_imem_re got %b expected 1", imem_re);
      else n_pass++;
      n_total++;
      if (imem_addr !== 32'h4000_0000) $display("FAIL release_addr got %h expected 40000000", imem_addr);
      else n_pass++;
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      do_reset();
      lat = 1;
      id_ready = 1'b1;
      for (int i = 0; i < 10; i++) clk_cycle();
      n_total++;
      if (pop_pc.size() != 8) $display("FAIL stream_count got %0d expected 8", pop_pc.size());
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         exp_pc = 32'h4000_0000 + 32'(4 * i);
         n_total++;
         if (pop_pc[i] !== exp_pc || pop_insn[i] !== (exp_pc ^ 32'hA5A5_A5A5))
            $display("FAIL stream_%0d got pc %h insn %h expected pc %h insn %h",
                     i, pop_pc[i], pop_insn[i], exp_pc, exp_pc ^ 32'hA5A5_A5A5);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      do_reset();
      lat = 1;
      id_ready = 1'b0;
      for (int i = 0; i < 5; i++) clk_cycle();
      n_total++;
      if (acc_addr.size() != 2) $display("FAIL bp_requests got %0d expected 2", acc_addr.size());
      else n_pass++;
      n_total++;
      if (imem_re !== 1'b0) $display("FAIL bp_imem_re got %b expected 0", imem_re);
      else n_pass++;
      n_total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h4000_0000)
         $display("FAIL bp_head got valid %b pc %h expected valid 1 pc 40000000", id_valid, id_pc);
      else n_pass++;
      id_ready = 1'b1;
      for (int i = 0; i < 10; i++) clk_cycle();
      n_total++;
      if (pop_pc.size() < 6) $display("FAIL bp_drain_count got %0d expected >=6", pop_pc.size());
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         exp_pc = 32'h4000_0000 + 32'(4 * i);
         n_total++;
         if (pop_pc[i] !== exp_pc || pop_insn[i] !== (exp_pc ^ 32'hA5A5_A5A5))
            $display("FAIL bp_order_%0d got pc %h insn %h expected pc %h", i, pop_pc[i], pop_insn[i], exp_pc);
         else n_pass++;
      end
   endtask

   task automatic test_redirect();
      do_reset();
      lat = 3;
      id_ready = 1'b1;
      clk_cycle();
      clk_cycle();
      fw_branch      = 1'b1;
      fw_branch_addr = 32'h4000_0102;
      #1;
      n_total++;
      if (imem_re !== 1'b0) $display("FAIL redir_no_req got %b expected 0", imem_re);
      else n_pass++;
      clk_cycle();
      fw_branch = 1'b0;
      n_total++;
      if (imem_addr !== 32'h4000_0100) $display("FAIL redir_addr got %h expected 40000100", imem_addr);
      else n_pass++;
      for (int i = 0; i < 10; i++) clk_cycle();
      n_total++;
      if (acc_addr.size() < 3 || acc_addr[2] !== 32'h4000_0100)
         $display("FAIL redir_first_req got %h expected 40000100", acc_addr[2]);
      else n_pass++;
      n_total++;
      if (pop_pc.size() < 2 || pop_pc[0] !== 32'h4000_0100 || pop_insn[0] !== 32'hE5A5_A4A5)
         $display("FAIL redir_first_pop got pc %h insn %h expected pc 40000100 insn e5a5a4a5",
                  pop_pc[0], pop_insn[0]);
      else n_pass++;
      n_total++;
      if (pop_pc[1] !== 32'h4000_0104) $display("FAIL redir_second_pop got %h expected 40000104", pop_pc[1]);
      else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      lat = 1;
      id_ready = 1'b0;
      for (int i = 0; i < 4; i++) clk_cycle();
      fw_branch      = 1'b1;
      fw_branch_addr = 32'hFFFF_FFFC;
      clk_cycle();
      fw_branch = 1'b0;
      n_total++;
      if (id_valid !== 1'b0) $display("FAIL wrap_flush got valid %b expected 0", id_valid);
      else n_pass++;
      n_total++;
      if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target got %h expected fffffffc", imem_addr);
      else n_pass++;
      id_ready = 1'b1;
      for (int i = 0; i < 6; i++) clk_cycle();
      n_total++;
      if (acc_addr.size() < 4 || acc_addr[3] !== 32'h0000_0000)
         $display("FAIL wrap_req got %h expected 00000000", acc_addr[3]);
      else n_pass++;
      n_total++;
      if (pop_pc.size() < 2 || pop_pc[0] !== 32'hFFFF_FFFC || pop_insn[0] !== 32'h5A5A_5A59)
         $display("FAIL wrap_pop0 got pc %h insn %h expected pc fffffffc insn 5a5a5a59", pop_pc[0], pop_insn[0]);
      else n_pass++;
      n_total++;
      if (pop_pc[1] !== 32'h0000_0000 || pop_insn[1] !== 32'hA5A5_A5A5)
         $display("FAIL wrap_pop1 got pc %h insn %h expected pc 00000000 insn a5a5a5a5", pop_pc[1], pop_insn[1]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      lat = 1;
      id_ready = 1'b0;
      for (int i = 0; i < 4; i++) clk_cycle();
      n_total++;
      if (id_valid !== 1'b1) $display("FAIL mid_prefill got valid %b expected 1", id_valid);
      else n_pass++;
      #2;
      rst = 1'b0;
      #1;
      n_total++;
      if (id_valid !== 1'b0 || id_pc !== 32'h0 || imem_re !== 1'b0)
         $display("FAIL mid_async got valid %b pc %h re %b expected 0 00000000 0", id_valid, id_pc, imem_re);
      else n_pass++;
      clear_model();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      id_ready = 1'b1;
      spurious = 1'b1;
      clk_cycle();
      spurious = 1'b0;
      for (int i = 0; i < 6; i++) clk_cycle();
      n_total++;
      if (acc_addr.size() < 1 || acc_addr[0] !== 32'h4000_0000)
         $display("FAIL mid_restart_req got %h expected 40000000", acc_addr[0]);
      else n_pass++;
      n_total++;
      if (pop_pc.size() < 1 || pop_pc[0] !== 32'h4000_0000 || pop_insn[0] !== 32'hE5A5_A5A5)
         $display("FAIL mid_restart_pop got pc %h insn %h expected pc 40000000 insn e5a5a5a5", pop_pc[0], pop_insn[0]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
